mat_vec_fifo_loader: RTL and testbench
======================================

Name: mat_vec_fifo_loader

Overview:
Upstream feeder for the 8x8 matrix-vector MAC array. On start, it reads the 8 matrix-A rows and the B vector from a word-addressed 64-bit memory through an Avalon-MM-style read interface. It unpacks each 64-bit word into 8 bytes and pushes them, one byte per cycle, into the ROWS A-FIFOs and the single B-FIFO. It asserts load_done when every FIFO is filled, which releases the MAC stage.

Parameters:
DATA_WIDTH, 8, width of one matrix/vector element
ROWS, 8, number of A rows (A-FIFOs)
COLS, 8, elements per row; COLS*DATA_WIDTH must equal 64
ADDR_WIDTH, 32, memory word-address width
BASE_ADDR, 0, word address of A row 0; row r at BASE_ADDR+r; B vector at BASE_ADDR+ROWS

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load when idle or done
mem_address  out  ADDR_WIDTH  word address of current read
mem_read  out  1  read request
mem_waitrequest  in  1  memory stall; request accepted when mem_read && !mem_waitrequest
mem_readdata  in  64  read data
mem_readdatavalid  in  1  mem_readdata valid this cycle
fill_wren  out  ROWS+1  one-hot FIFO write enable; bits 0..ROWS-1 = A-FIFO r, bit ROWS = B-FIFO
fill_data  out  DATA_WIDTH  byte being written
fifo_full  in  ROWS+1  full flags, same indexing as fill_wren
busy  out  1  high in any state other than IDLE/DONE
load_done  out  1  high in DONE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; row counter, byte counter and word register cleared. Reset mid-load aborts immediately with no partial-state retention. FIFO flushing is the consumer's job.
- States: IDLE, REQ, WAIT, PUSH, DONE.
- IDLE: start=1 -> REQ with row=0.
- REQ:
  - mem_read=1 and mem_address=BASE_ADDR+row, held stable while mem_waitrequest=1.
  - On acceptance (mem_waitrequest=0) -> WAIT.
- WAIT:
  - mem_read=0.
  - On mem_readdatavalid=1, capture mem_readdata into word register -> PUSH, byte index=0.
  - Only one read is ever outstanding.
  - readdatavalid seen in any state other than WAIT is ignored.
- PUSH:
  - Target FIFO t=row.
  - Each cycle with fifo_full[t]=0: fill_wren[t]=1 and fill_data = byte (COLS-1-idx) of the word; the MSB byte [63:56] goes first and [7:0] goes last. idx then increments.
  - fifo_full[t]=1: fill_wren=0, idx holds (stall, no data loss).
  - After the write with idx=COLS-1: if row==ROWS -> DONE, else row++ and -> REQ.
- DONE:
  - load_done=1, busy=0.
  - start=1 -> REQ with row=0, load_done drops the next cycle.
- start is ignored while busy.
- fill_wren is registered, so at most one bit is high in any cycle.
- Latency with waitrequest=0 and 1-cycle read latency: 10 cycles per word (1 REQ, 1 WAIT, 8 PUSH). load_done rises 90 cycles after the start edge.
- No arithmetic beyond counters. row counter is clog2(ROWS+1) bits; idx counter is clog2(COLS) bits and wraps only via the state transition.

Decomposition:
- Package mat_vec_pkg holds:
  - loader_state_e enum (IDLE, REQ, WAIT, PUSH, DONE)
  - localparams MAT_ROWS=8, MAT_COLS=8, ELEM_W=8, MEM_DATA_W=64
- The MAC stage shares the same package.
- No sub-module; the byte unpacker is an in-module shift/index mux.
- For simulation, the bench provides a memory model with configurable waitrequest and read latency.

Test Plan:
- Basic load: mem[0..7]=64'h0102030405060708+r*64'h0808080808080808, mem[8]=64'h0101010101010101, zero wait, latency 1, start pulse -> FIFO0 receives 01..08 in order, FIFO7 receives 39..40, B-FIFO receives eight 01s; load_done=1 exactly 90 cycles after start; mem_address sequence 0..8.
- Waitrequest stall: hold mem_waitrequest=1 for 3 cycles on row 2 -> mem_address=2 and mem_read=1 stable throughout, exactly one read accepted, load_done at 93 cycles.
- Full back-pressure: assert fifo_full[4] for 5 cycles after the 3rd byte of row 4 -> fill_wren[4]=0 during the stall, the 4th byte is written unchanged after release, no byte is duplicated or dropped (8 writes total to FIFO4).
- Read latency 4: readdatavalid arrives 4 cycles after acceptance -> correct data; load_done at 9*(1+4+8)=117 cycles; a spurious readdatavalid pulse in PUSH is ignored.
- Reset mid-op: drop rst_n during row 5 PUSH -> all outputs 0 asynchronously, state IDLE; a following start performs a full clean load from address 0.
- Restart and ignore: a start pulse while busy has no effect; a start in DONE clears load_done next cycle and repeats the 9-word load identically.

Source files
------------

// File: rtl/mat_vec_pkg.sv
// Types and dimensions shared by the matrix-vector loader and the MAC stage.
package mat_vec_pkg;

  localparam int MAT_ROWS   = 8;
  localparam int MAT_COLS   = 8;
  localparam int ELEM_W     = 8;
  localparam int MEM_DATA_W = 64;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, DONE} loader_state_e;

endpackage

// File: rtl/mat_vec_fifo_loader.sv
// Reads the A rows and B vector from 64-bit memory and feeds them byte-wise
// (MSB byte first) into the ROWS A-FIFOs and the B-FIFO.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | read request held on the bus until accepted
// WAIT  | waiting for the single outstanding readdatavalid
// PUSH  | writing COLS bytes of the captured word into FIFO row_q
// DONE  | all FIFOs loaded, load_done high
module mat_vec_fifo_loader
  import mat_vec_pkg::*;
#(
  parameter int                    DATA_WIDTH = ELEM_W,
  parameter int                    ROWS       = MAT_ROWS,
  parameter int                    COLS       = MAT_COLS,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  input  logic                  mem_waitrequest,
  input  logic [MEM_DATA_W-1:0] mem_readdata,
  input  logic                  mem_readdatavalid,
  output logic [ROWS:0]         fill_wren,
  output logic [DATA_WIDTH-1:0] fill_data,
  input  logic [ROWS:0]         fifo_full,
  output logic                  busy,
  output logic                  load_done
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int IW = $clog2(COLS);
  localparam int WW = COLS * DATA_WIDTH;

  loader_state_e         state_q;
  logic [RW-1:0]         row_q;
  logic [IW-1:0]         idx_q;
  logic [WW-1:0]         word_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic                  mem_read_q;
  logic [ROWS:0]         fill_wren_q;
  logic [DATA_WIDTH-1:0] fill_data_q;
  logic                  busy_q;
  logic                  load_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      row_q         <= '0;
      idx_q         <= '0;
      word_q        <= '0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      fill_wren_q   <= '0;
      fill_data_q   <= '0;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      fill_wren_q <= '0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q       <= REQ;
            row_q         <= '0;
            mem_read_q    <= 1'b1;
            mem_address_q <= BASE_ADDR;
            busy_q        <= 1'b1;
            load_done_q   <= 1'b0;
          end
        end
        REQ: begin
          if (!mem_waitrequest) begin
            mem_read_q <= 1'b0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_readdatavalid) begin
            word_q  <= mem_readdata;
            idx_q   <= '0;
            state_q <= PUSH;
          end
        end
        PUSH: begin
          // The word register shifts left so the next byte is always on top.
          if (!fifo_full[row_q]) begin
            fill_wren_q[row_q] <= 1'b1;
            fill_data_q        <= word_q[WW-1 -: DATA_WIDTH];
            word_q             <= word_q << DATA_WIDTH;
            idx_q              <= idx_q + 1'b1;
            if (idx_q == IW'(COLS - 1)) begin
              if (row_q == RW'(ROWS)) begin
                state_q     <= DONE;
                busy_q      <= 1'b0;
                load_done_q <= 1'b1;
              end else begin
                row_q         <= row_q + 1'b1;
                state_q       <= REQ;
                mem_read_q    <= 1'b1;
                mem_address_q <= BASE_ADDR + ADDR_WIDTH'(row_q + 1'b1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_address = mem_address_q;
  assign mem_read    = mem_read_q;
  assign fill_wren   = fill_wren_q;
  assign fill_data   = fill_data_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_mat_vec_fifo_loader.sv
// Self-checking bench: memory model with waitrequest/latency, FIFO capture, table-driven loads.
module tb_mat_vec_fifo_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [63:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [8:0]  fill_wren;
  logic [7:0]  fill_data;
  logic [8:0]  fifo_full;
  logic        busy;
  logic        load_done;

  mat_vec_fifo_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid),
    .fill_wren(fill_wren), .fill_data(fill_data), .fifo_full(fifo_full),
    .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat;
    int stall_addr;
    int stall_n;
    int full_idx;
    int full_after;
    int full_n;
    bit spur;
    bit ign;
    int exp_cycles;
  } cfg_t;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem [16];
  logic [7:0]  got [9][$];
  logic [31:0] addr_log [$];

  int          lat;
  logic [31:0] stall_addr;
  int          stall_left;
  int          full_idx, full_after, full_n, fcnt;
  bit          ftrig;
  int          spur_left;
  int          pend;
  logic [63:0] pdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // memory model, FIFO capture and back-pressure control, all evaluated mid-cycle
  initial begin
    logic [8:0] was_full;
    logic       was_wait;
    mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
    fifo_full = '0; pend = 0; pdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0;
        fifo_full = '0; fcnt = 0;
      end else begin
        was_full = fifo_full;
        was_wait = mem_waitrequest;
        if (fill_wren != '0) begin
          chk("wren_onehot", 64'($onehot(fill_wren)), 64'd1);
          for (int t = 0; t < 9; t++)
            if (fill_wren[t]) got[t].push_back(fill_data);
        end
        if (was_full != '0) chk("no_wren_while_full", 64'(fill_wren & was_full), 64'd0);
        if (was_wait) chk("req_held_in_stall", {31'd0, mem_read, mem_address}, {31'd0, 1'b1, stall_addr});
        if (fcnt > 0) begin
          fcnt--;
          if (fcnt == 0) fifo_full = '0;
        end
        if (!ftrig && full_idx >= 0 && full_n > 0 && got[full_idx].size() == full_after) begin
          fifo_full[full_idx] = 1'b1;
          fcnt  = full_n;
          ftrig = 1'b1;
        end
        mem_readdatavalid = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin mem_readdatavalid = 1'b1; mem_readdata = pdata; end
        end else if (spur_left > 0 && fill_wren != '0) begin
          mem_readdatavalid = 1'b1;
          mem_readdata = 64'hDEAD_BEEF_0BAD_F00D;
          spur_left--;
        end
        if (mem_read && stall_left > 0 && mem_address == stall_addr) begin
          mem_waitrequest = 1'b1;
          stall_left--;
        end else begin
          mem_waitrequest = 1'b0;
          if (mem_read) begin
            addr_log.push_back(mem_address);
            pend  = lat;
            pdata = mem[mem_address[3:0]];
          end
        end
      end
    end
  end

  task automatic setup(input cfg_t c);
    for (int t = 0; t < 9; t++) got[t].delete();
    addr_log.delete();
    lat        = c.lat;
    stall_addr = (c.stall_addr < 0) ? 32'hFFFF_FFFF : 32'(c.stall_addr);
    stall_left = c.stall_n;
    full_idx   = c.full_idx;
    full_after = c.full_after;
    full_n     = c.full_n;
    fcnt       = 0;
    ftrig      = 1'b0;
    spur_left  = c.spur ? 3 : 0;
  endtask

  task automatic check_contents(input string tag);
    logic [63:0] w;
    chk({tag, ":n_reads"}, 64'(addr_log.size()), 64'd9);
    for (int r = 0; r < 9 && r < addr_log.size(); r++)
      chk({tag, ":addr"}, 64'(addr_log[r]), 64'(r));
    for (int r = 0; r < 9; r++) begin
      chk({tag, ":fifo_count"}, 64'(got[r].size()), 64'd8);
      w = '0;
      for (int i = 0; i < 8 && i < got[r].size(); i++) w = {w[55:0], got[r][i]};
      chk({tag, ":fifo_bytes"}, w, mem[r]);
    end
  endtask

  // called at a negedge; start is sampled at the next posedge
  task automatic run_load(input cfg_t c, input string tag);
    int n;
    setup(c);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":done_low_after_start"}, 64'(load_done), 64'd0);
    chk({tag, ":busy_after_start"}, 64'(busy), 64'd1);
    n = 0;
    while (!load_done && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (c.ign && n == 30) begin
        chk({tag, ":busy_mid"}, 64'(busy), 64'd1);
        start = 1'b1;
      end else start = 1'b0;
    end
    chk({tag, ":cycles_to_done"}, 64'(n), 64'(c.exp_cycles));
    chk({tag, ":busy_in_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, ":done_held"}, 64'(load_done), 64'd1);
    check_contents(tag);
  endtask

  cfg_t tbl [9];
  cfg_t cb;

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    cb = '{1, -1, 0, -1, 0, 0, 1'b0, 1'b0, 90};
    setup(cb);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {12'd0, mem_read, mem_address, fill_wren, fill_data, busy, load_done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {12'd0, mem_read, mem_address, fill_wren, fill_data, busy, load_done}, 64'd0);

    tbl[0] = '{1, -1, 0, -1, 0, 0, 1'b0, 1'b0, 90};
    tbl[1] = '{1,  2, 3, -1, 0, 0, 1'b0, 1'b0, 93};
    tbl[2] = '{1, -1, 0,  4, 3, 5, 1'b0, 1'b0, 95};
    tbl[3] = '{4, -1, 0, -1, 0, 0, 1'b1, 1'b0, 117};
    tbl[4] = '{1, -1, 0, -1, 0, 0, 1'b0, 1'b1, 90};
    for (int k = 5; k < 9; k++) begin
      tbl[k].lat        = $urandom_range(1, 4);
      tbl[k].stall_addr = $urandom_range(0, 8);
      tbl[k].stall_n    = $urandom_range(0, 4);
      tbl[k].full_idx   = $urandom_range(0, 8);
      tbl[k].full_after = $urandom_range(1, 7);
      tbl[k].full_n     = $urandom_range(0, 6);
      tbl[k].spur       = 1'($urandom_range(0, 1));
      tbl[k].ign        = 1'($urandom_range(0, 1));
      tbl[k].exp_cycles = 9 * (1 + tbl[k].lat + 8) + tbl[k].stall_n + tbl[k].full_n;
    end

    for (int k = 0; k < 9; k++) begin
      for (int r = 0; r < 9; r++) begin
        if (k == 0 || k == 4)
          mem[r] = (r < 8) ? 64'h0102030405060708 + 64'(r) * 64'h0808080808080808
                           : 64'h0101010101010101;
        else
          mem[r] = {$urandom, $urandom};
      end
      run_load(tbl[k], $sformatf("load%0d", k));
    end

    // asynchronous reset in the middle of row 5, then a clean reload
    for (int r = 0; r < 9; r++) mem[r] = {$urandom, $urandom};
    setup(cb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (got[5].size() < 3 && n < 500) begin @(negedge clk); n++; end
    chk("reached_row5", 64'(n < 500), 64'd1);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {12'd0, mem_read, mem_address, fill_wren, fill_data, busy, load_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {12'd0, mem_read, mem_address, fill_wren, fill_data, busy, load_done}, 64'd0);
    run_load(cb, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
